// File: rtl/riscv_mem_pkg.sv
// Shared load/store definitions: funct3 access codes, responder states, latched request record.
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic        write;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    // Halfwords need an even address, words a multiple of four; byte and unknown codes never fault.
    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        logic res;
        res = 1'b0;
        if (funct3 == F3_H || funct3 == F3_HU) begin
            res = offset[0];
        end else if (funct3 == F3_W) begin
            res = (offset != 2'b00);
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: merges store data into the old word and extracts/extends loads.
module dmem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    output logic [31:0] store_word_o,
    output logic        store_en_o,
    output logic [31:0] load_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // A halfword lives at bit 0 or 16 depending only on offset[1]; offset[0] is ignored for it.
    assign byte_sel = word_i[{offset_i, 3'b000} +: 8];
    assign half_sel = word_i[{offset_i[1], 4'b0000} +: 16];

    always_comb begin
        store_word_o = word_i;
        store_en_o   = 1'b0;
        case (funct3_i)
            F3_B: begin
                store_en_o                          = 1'b1;
                store_word_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            F3_H: begin
                store_en_o                               = 1'b1;
                store_word_o[{offset_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            end
            F3_W: begin
                store_en_o   = 1'b1;
                store_word_o = wdata_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        load_data_o = 32'h0;
        case (funct3_i)
            F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
            F3_W:    load_data_o = word_i;
            F3_BU:   load_data_o = {24'h0, byte_sel};
            F3_HU:   load_data_o = {16'h0, half_sel};
            default: load_data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with internal word RAM; MemReady pulses WAIT_STATES+1 cycles after acceptance.
// MemReq is only sampled in IDLE; defining DMEM_MISALIGN_FAULT_EN enables misalignment faults on MemFault.
module dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        MemReq,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        MemFault
);

    localparam int         IDX      = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    mem_req_t       req_q, req_d;
    logic [31:0]    rdata_q, rdata_d;
    logic [31:0]    mem_q [DEPTH_WORDS];

    mem_req_t       in_req, cur_req;
    logic [IDX-1:0] cur_idx;
    logic [31:0]    cur_word, store_word, load_data;
    logic           store_en, cur_fault, accept, enter_resp, mem_we;
    logic           unused_addr_hi;

    assign in_req = '{write: MemWrite, funct3: Funct3, addr: Addr, wdata: WriteData};
    assign accept = (state_q == ST_IDLE) && MemReq;

    // With zero wait states a load resolves on its accept edge, so IDLE steers the live inputs.
    assign cur_req        = (state_q == ST_IDLE) ? in_req : req_q;
    assign cur_idx        = cur_req.addr[IDX+1:2];
    assign cur_word       = mem_q[cur_idx];
    assign unused_addr_hi = ^cur_req.addr[31:IDX+2];

`ifdef DMEM_MISALIGN_FAULT_EN
    assign cur_fault = misaligned(cur_req.funct3, cur_req.addr[1:0]);
`else
    assign cur_fault = 1'b0;
`endif

    dmem_lane_align u_lane_align (
        .word_i       (cur_word),
        .wdata_i      (cur_req.wdata),
        .funct3_i     (cur_req.funct3),
        .offset_i     (cur_req.addr[1:0]),
        .store_word_o (store_word),
        .store_en_o   (store_en),
        .load_data_o  (load_data)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (MemReq) state_d = (WAIT_STATES > 0) ? ST_BUSY : ST_RESP;
            ST_BUSY: if (cnt_q <= 4'd1) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);

    always_comb begin
        cnt_d   = cnt_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        if (accept) begin
            req_d = in_req;
            cnt_d = WAIT_CNT;
        end else if (state_q == ST_BUSY) begin
            cnt_d = cnt_q - 4'd1;
        end
        if (enter_resp) begin
            if (cur_fault) begin
                rdata_d = 32'h0;
            end else if (!cur_req.write) begin
                rdata_d = load_data;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            cnt_q   <= 4'd0;
            req_q   <= '0;
            rdata_q <= 32'h0;
        end else begin
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
        end
    end

    // The store commits on the edge leaving RESP; a reset on that edge drops it.
    assign mem_we = (state_q == ST_RESP) && req_q.write && store_en && !cur_fault && !Reset;

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_q[cur_idx] <= store_word;
        end
    end

    always_comb begin
        MemReady = 1'b0;
        MemFault = 1'b0;
        if (state_q == ST_RESP) begin
            MemReady = 1'b1;
            MemFault = cur_fault;
        end
    end

    assign ReadData = rdata_q;

endmodule
